// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, synchronous preset and terminal-count pulse.
// Optional saturate mode is enabled by defining MOD_COUNTER_SAT_EN (adds the sat port).
module mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);

  // One extra bit so MODULUS = 2^WIDTH compares exactly.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             at_top, at_bot;

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int unsigned   PW       = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_q, pre_d;

      always_comb begin
        pre_d = pre_q;
        if (load) begin
          pre_d = '0;
        end else if (en) begin
          pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      assign tick = en && (pre_q == PRE_LAST);
    end else begin : g_nopre
      assign tick = en;
    end
  endgenerate

  assign at_top = (count_q == TOP);
  assign at_bot = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} < MOD_W) ? load_val : TOP;
    end else if (tick) begin
      if (up) begin
        if (at_top) begin
          tc_d    = 1'b1;
          count_d = '0;
`ifdef MOD_COUNTER_SAT_EN
          if (sat) count_d = count_q;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          tc_d    = 1'b1;
          count_d = TOP;
`ifdef MOD_COUNTER_SAT_EN
          if (sat) count_d = count_q;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: WIDTH=4, MODULUS=10 with PRESCALE=1 and PRESCALE=3 instances.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_val;
`ifdef MOD_COUNTER_SAT_EN
  logic       sat;
`endif
  logic [3:0] c1, c3;
  logic       tc1, tc3, z1, z3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut_p1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_SAT_EN
    .sat(sat),
`endif
    .count(c1), .tc(tc1), .zero(z1)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_dut_p3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_SAT_EN
    .sat(sat),
`endif
    .count(c3), .tc(tc3), .zero(z3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
`ifdef MOD_COUNTER_SAT_EN
    sat = 1'b0;
`endif
    cyc();
    chk("rst_count_p1", 32'(c1), 32'd0);
    chk("rst_tc_p1",    32'(tc1), 32'd0);
    chk("rst_zero_p1",  32'(z1), 32'd1);
    chk("rst_count_p3", 32'(c3), 32'd0);

    // Up-count, PRESCALE=1: 1..9,0 with tc on the wrap, twice.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("up_count", 32'(c1), 32'(k % 10));
      chk("up_tc",    32'(tc1), (k % 10 == 0) ? 32'd1 : 32'd0);
    end
    chk("up_zero", 32'(z1), 32'd1);

    // Down-count from reset: first step wraps to 9 with tc.
    do_reset();
    en = 1'b1; up = 1'b0;
    cyc();
    chk("dn_count1", 32'(c1), 32'd9);
    chk("dn_tc1",    32'(tc1), 32'd1);
    chk("dn_zero1",  32'(z1), 32'd0);
    cyc();
    chk("dn_count2", 32'(c1), 32'd8);
    chk("dn_tc2",    32'(tc1), 32'd0);
    cyc();
    chk("dn_count3", 32'(c1), 32'd7);

    // PRESCALE=3 with en 1,1,0,0,1: step only on the third enabled cycle.
    do_reset();
    up = 1'b1;
    en = 1'b1; cyc(); chk("ps_e1", 32'(c3), 32'd0);
    en = 1'b1; cyc(); chk("ps_e2", 32'(c3), 32'd0);
    en = 1'b0; cyc(); chk("ps_h1", 32'(c3), 32'd0);
    en = 1'b0; cyc(); chk("ps_h2", 32'(c3), 32'd0);
    en = 1'b1; cyc(); chk("ps_e3", 32'(c3), 32'd1);
    chk("ps_tc", 32'(tc3), 32'd0);
    cyc(); chk("ps_e4", 32'(c3), 32'd1);
    cyc(); chk("ps_e5", 32'(c3), 32'd1);
    cyc(); chk("ps_e6", 32'(c3), 32'd2);

    // Load: out-of-range clamps to MODULUS-1, en ignored, prescaler cleared.
    load = 1'b1; load_val = 4'd12; en = 1'b1;
    cyc();
    chk("ld12_p1", 32'(c1), 32'd9);
    chk("ld12_p3", 32'(c3), 32'd9);
    chk("ld12_tc", 32'(tc1), 32'd0);
    load_val = 4'd10;
    cyc();
    chk("ld10_p1", 32'(c1), 32'd9);
    load_val = 4'd5;
    cyc();
    chk("ld5_p1", 32'(c1), 32'd5);
    chk("ld5_p3", 32'(c3), 32'd5);
    load = 1'b0;
    cyc(); chk("ldrun1_p3", 32'(c3), 32'd5); chk("ldrun1_p1", 32'(c1), 32'd6);
    cyc(); chk("ldrun2_p3", 32'(c3), 32'd5);
    cyc(); chk("ldrun3_p3", 32'(c3), 32'd6);

    // Reset mid-prescale with count=7, then a full prescale interval again.
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    cyc();
    chk("mid_p3", 32'(c3), 32'd7);
    rst = 1'b1;
    cyc();
    chk("mrst_count", 32'(c3), 32'd0);
    chk("mrst_tc",    32'(tc3), 32'd0);
    chk("mrst_zero",  32'(z3), 32'd1);
    rst = 1'b0;
    cyc(); chk("rr1_p3", 32'(c3), 32'd0);
    cyc(); chk("rr2_p3", 32'(c3), 32'd0);
    cyc(); chk("rr3_p3", 32'(c3), 32'd1);

`ifdef MOD_COUNTER_SAT_EN
    // Saturation: hold at the boundary while flagging tc.
    sat = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0;
    cyc();
    chk("sat_up_count", 32'(c1), 32'd9);
    chk("sat_up_tc",    32'(tc1), 32'd1);
    up = 1'b0;
    cyc();
    chk("sat_dn_count", 32'(c1), 32'd8);
    chk("sat_dn_tc",    32'(tc1), 32'd0);
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    cyc();
    chk("sat_lo_count", 32'(c1), 32'd0);
    chk("sat_lo_tc",    32'(tc1), 32'd1);
    sat = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
